// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package arb_pkg;

   typedef enum logic {IDLE, OWNED} arb_state_e;

   typedef enum logic {ARB_RR, ARB_PRIO} arb_mode_e;

   // Index width never collapses to zero, even for degenerate requester counts.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/arb_pick.sv
// Circular priority picker: first set bit of mask at or after start, wrapping.
module arb_pick import arb_pkg::*; #(
   parameter int DEVICE_NUM = 4,
   parameter int IDX_W      = idx_width(DEVICE_NUM)
) (
   input  logic [DEVICE_NUM-1:0] mask,
   input  logic [IDX_W-1:0]      start,
   output logic [DEVICE_NUM-1:0] onehot,
   output logic [IDX_W-1:0]      index,
   output logic                  found
);

   // start is always below DEVICE_NUM, so one subtraction is enough to wrap.
   always_comb begin
      onehot = '0;
      index  = '0;
      found  = 1'b0;
      for (int k = 0; k < DEVICE_NUM; k++) begin
         int pos;
         pos = int'(start) + k;
         if (pos >= DEVICE_NUM) pos = pos - DEVICE_NUM;
         if (!found && mask[pos]) begin
            found       = 1'b1;
            onehot[pos] = 1'b1;
            index       = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Arbiter with per-requester quota, fixed-priority mode and a lock that
// suspends quota preemption for atomic sequences.
module weighted_rr_arbiter import arb_pkg::*; #(
   parameter int DEVICE_NUM   = 4,
   parameter int WEIGHT_WIDTH = 4,
   localparam int IDX_W       = idx_width(DEVICE_NUM)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [DEVICE_NUM-1:0]            req,
   input  logic [DEVICE_NUM*WEIGHT_WIDTH-1:0] weight,
   input  logic                             prio_mode,
   input  logic                             lock,
   output logic [DEVICE_NUM-1:0]            grant,
   output logic [IDX_W-1:0]                 grant_index,
   output logic                             busy,
   output logic [WEIGHT_WIDTH-1:0]          hold_cnt
);

   arb_state_e              state;
   arb_mode_e               mode;
   logic [DEVICE_NUM-1:0]   others;
   logic [DEVICE_NUM-1:0]   pick_mask;
   logic [DEVICE_NUM-1:0]   pick_onehot;
   logic [IDX_W-1:0]        pick_start;
   logic [IDX_W-1:0]        pick_index;
   logic [IDX_W-1:0]        next_index;
   logic                    pick_found;
   logic                    holder_req;
   logic                    expire;
   logic [WEIGHT_WIDTH-1:0] holder_weight;

   assign mode       = prio_mode ? ARB_PRIO : ARB_RR;
   assign others     = req & ~grant;
   assign holder_req = |(req & grant);
   assign next_index = (grant_index == IDX_W'(DEVICE_NUM - 1)) ? '0 : grant_index + 1'b1;

   always_comb begin
      holder_weight = '0;
      for (int i = 0; i < DEVICE_NUM; i++) begin
         if (grant_index == IDX_W'(i)) holder_weight = weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
   end

   // A zero quota means unlimited; expiry only matters when someone else waits.
   assign expire = (state == OWNED) && (holder_weight != '0) && (hold_cnt >= holder_weight)
                   && !lock && (|others);

   // A still-requesting holder is excluded so preemption always moves on.
   always_comb begin
      pick_mask  = req;
      pick_start = next_index;
      case (state)
         IDLE:  pick_mask = req;
         OWNED: pick_mask = holder_req ? others : req;
      endcase
      case (mode)
         ARB_RR:   pick_start = next_index;
         ARB_PRIO: pick_start = '0;
      endcase
   end

   arb_pick #(
      .DEVICE_NUM (DEVICE_NUM),
      .IDX_W      (IDX_W)
   ) u_pick (
      .mask   (pick_mask),
      .start  (pick_start),
      .onehot (pick_onehot),
      .index  (pick_index),
      .found  (pick_found)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         grant       <= '0;
         grant_index <= IDX_W'(DEVICE_NUM - 1);
         busy        <= 1'b0;
         hold_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  state       <= OWNED;
                  grant       <= pick_onehot;
                  grant_index <= pick_index;
                  busy        <= 1'b1;
                  hold_cnt    <= WEIGHT_WIDTH'(1);
               end
            end
            OWNED: begin
               if (!holder_req) begin
                  if (pick_found) begin
                     grant       <= pick_onehot;
                     grant_index <= pick_index;
                     hold_cnt    <= WEIGHT_WIDTH'(1);
                  end else begin
                     state    <= IDLE;
                     grant    <= '0;
                     busy     <= 1'b0;
                     hold_cnt <= '0;
                  end
               end else if (expire) begin
                  grant       <= pick_onehot;
                  grant_index <= pick_index;
                  hold_cnt    <= WEIGHT_WIDTH'(1);
               end else if (hold_cnt != '1) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Self-checking bench: table of vectors and hand sequences feeding a scoreboard queue.
module tb_weighted_rr_arbiter;

   typedef struct {
      logic [3:0]  req;
      logic [15:0] weight;
      logic        prio;
      logic        lock;
      logic [3:0]  grant;
      logic [1:0]  idx;
      logic        busy;
      logic [3:0]  hold;
   } vec_t;

   typedef struct {
      logic [3:0] grant;
      logic [1:0] idx;
      logic       busy;
      logic [3:0] hold;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] weight;
   logic        prio_mode;
   logic        lock;
   logic [3:0]  grant;
   logic [1:0]  grant_index;
   logic        busy;
   logic [3:0]  hold_cnt;

   logic [2:0]  req3;
   logic [11:0] weight3;
   logic        prio3;
   logic        lock3;
   logic [2:0]  grant3;
   logic [1:0]  grant_index3;
   logic        busy3;
   logic [3:0]  hold_cnt3;

   exp_t exp_q[$];
   vec_t tbl[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   weighted_rr_arbiter #(.DEVICE_NUM(4), .WEIGHT_WIDTH(4)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .weight      (weight),
      .prio_mode   (prio_mode),
      .lock        (lock),
      .grant       (grant),
      .grant_index (grant_index),
      .busy        (busy),
      .hold_cnt    (hold_cnt)
   );

   weighted_rr_arbiter #(.DEVICE_NUM(3), .WEIGHT_WIDTH(4)) u_dut3 (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req3),
      .weight      (weight3),
      .prio_mode   (prio3),
      .lock        (lock3),
      .grant       (grant3),
      .grant_index (grant_index3),
      .busy        (busy3),
      .hold_cnt    (hold_cnt3)
   );

   function automatic vec_t mk(logic [3:0] r, logic [15:0] w, logic p, logic l,
                               logic [3:0] g, logic [1:0] i, logic b, logic [3:0] h);
      vec_t v;
      v.req = r; v.weight = w; v.prio = p; v.lock = l;
      v.grant = g; v.idx = i; v.busy = b; v.hold = h;
      return v;
   endfunction

   task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [3:0] g, input logic [1:0] i, input logic b, input logic [3:0] h);
      exp_t e;
      e.grant = g; e.idx = i; e.busy = b; e.hold = h;
      exp_q.push_back(e);
   endtask

   task automatic check_output(input string tag, input logic [3:0] g, input logic [1:0] i,
                               input logic b, input logic [3:0] h);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("[TB] FAIL %s: scoreboard empty", tag);
         return;
      end
      e = exp_q.pop_front();
      compare({tag, ".grant"}, 32'(g), 32'(e.grant));
      compare({tag, ".index"}, 32'(i), 32'(e.idx));
      compare({tag, ".busy"},  32'(b), 32'(e.busy));
      compare({tag, ".hold"},  32'(h), 32'(e.hold));
   endtask

   // Drive at the falling edge, let one rising edge pass, sample at the next falling edge.
   task automatic apply_stimulus(input vec_t v, input string tag);
      req       = v.req;
      weight    = v.weight;
      prio_mode = v.prio;
      lock      = v.lock;
      push_exp(v.grant, v.idx, v.busy, v.hold);
      @(negedge clk);
      check_output(tag, grant, grant_index, busy, hold_cnt);
   endtask

   task automatic step3(input logic [2:0] r, input logic [2:0] g, input logic [1:0] i,
                        input logic b, input logic [3:0] h, input string tag);
      req3 = r;
      push_exp({1'b0, g}, i, b, h);
      @(negedge clk);
      check_output(tag, {1'b0, grant3}, grant_index3, busy3, hold_cnt3);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst_n = 1'b0; req = '0; weight = '0; prio_mode = 1'b0; lock = 1'b0;
      req3 = '0; weight3 = '0; prio3 = 1'b0; lock3 = 1'b0;

      // Rotation on release, all quotas unlimited
      tbl.push_back(mk(4'b1111, 16'h0000, 0, 0, 4'b0001, 2'd0, 1, 4'd1));
      tbl.push_back(mk(4'b1110, 16'h0000, 0, 0, 4'b0010, 2'd1, 1, 4'd1));
      tbl.push_back(mk(4'b1101, 16'h0000, 0, 0, 4'b0100, 2'd2, 1, 4'd1));
      tbl.push_back(mk(4'b1011, 16'h0000, 0, 0, 4'b1000, 2'd3, 1, 4'd1));
      tbl.push_back(mk(4'b0111, 16'h0000, 0, 0, 4'b0001, 2'd0, 1, 4'd1));
      tbl.push_back(mk(4'b0001, 16'h0000, 0, 0, 4'b0001, 2'd0, 1, 4'd2));
      tbl.push_back(mk(4'b0000, 16'h0000, 0, 0, 4'b0000, 2'd0, 0, 4'd0));
      // Quotas 3 and 2 alternating
      tbl.push_back(mk(4'b0011, 16'h0023, 0, 0, 4'b0010, 2'd1, 1, 4'd1));
      tbl.push_back(mk(4'b0011, 16'h0023, 0, 0, 4'b0010, 2'd1, 1, 4'd2));
      tbl.push_back(mk(4'b0011, 16'h0023, 0, 0, 4'b0001, 2'd0, 1, 4'd1));
      tbl.push_back(mk(4'b0011, 16'h0023, 0, 0, 4'b0001, 2'd0, 1, 4'd2));
      tbl.push_back(mk(4'b0011, 16'h0023, 0, 0, 4'b0001, 2'd0, 1, 4'd3));
      tbl.push_back(mk(4'b0011, 16'h0023, 0, 0, 4'b0010, 2'd1, 1, 4'd1));
      tbl.push_back(mk(4'b0011, 16'h0023, 0, 0, 4'b0010, 2'd1, 1, 4'd2));
      tbl.push_back(mk(4'b0011, 16'h0023, 0, 0, 4'b0001, 2'd0, 1, 4'd1));
      // Lock holds device 0 past its quota; switch one edge after lock falls
      tbl.push_back(mk(4'b0011, 16'h0023, 0, 1, 4'b0001, 2'd0, 1, 4'd2));
      tbl.push_back(mk(4'b0011, 16'h0023, 0, 1, 4'b0001, 2'd0, 1, 4'd3));
      tbl.push_back(mk(4'b0011, 16'h0023, 0, 1, 4'b0001, 2'd0, 1, 4'd4));
      tbl.push_back(mk(4'b0011, 16'h0023, 0, 1, 4'b0001, 2'd0, 1, 4'd5));
      tbl.push_back(mk(4'b0011, 16'h0023, 0, 0, 4'b0010, 2'd1, 1, 4'd1));
      tbl.push_back(mk(4'b0000, 16'h0023, 0, 0, 4'b0000, 2'd1, 0, 4'd0));
      // Priority mode: lowest index wins, expiry excludes the holder
      tbl.push_back(mk(4'b1010, 16'h0000, 1, 0, 4'b0010, 2'd1, 1, 4'd1));
      tbl.push_back(mk(4'b1100, 16'h0000, 1, 0, 4'b0100, 2'd2, 1, 4'd1));
      tbl.push_back(mk(4'b0000, 16'h0000, 1, 0, 4'b0000, 2'd2, 0, 4'd0));
      tbl.push_back(mk(4'b0011, 16'h0001, 1, 0, 4'b0001, 2'd0, 1, 4'd1));
      tbl.push_back(mk(4'b0011, 16'h0001, 1, 0, 4'b0010, 2'd1, 1, 4'd1));
      tbl.push_back(mk(4'b0011, 16'h0001, 1, 0, 4'b0010, 2'd1, 1, 4'd2));
      tbl.push_back(mk(4'b0000, 16'h0001, 1, 0, 4'b0000, 2'd1, 0, 4'd0));
      // Mode change alone never preempts
      tbl.push_back(mk(4'b1001, 16'h0000, 0, 0, 4'b1000, 2'd3, 1, 4'd1));
      tbl.push_back(mk(4'b1001, 16'h0000, 1, 0, 4'b1000, 2'd3, 1, 4'd2));
      tbl.push_back(mk(4'b0000, 16'h0000, 0, 0, 4'b0000, 2'd3, 0, 4'd0));

      repeat (2) @(negedge clk);
      push_exp(4'b0000, 2'd3, 1'b0, 4'd0);
      check_output("reset", grant, grant_index, busy, hold_cnt);
      push_exp(4'b0000, 2'd2, 1'b0, 4'd0);
      check_output("reset3", {1'b0, grant3}, grant_index3, busy3, hold_cnt3);
      rst_n = 1'b1;

      foreach (tbl[k]) apply_stimulus(tbl[k], $sformatf("vec%0d", k));

      // Saturation of hold_cnt, then a late quota and a late contender
      for (int k = 1; k <= 17; k++)
         apply_stimulus(mk(4'b0001, 16'h0000, 0, 0, 4'b0001, 2'd0, 1, (k > 15) ? 4'd15 : 4'(k)),
                        $sformatf("sat%0d", k));
      apply_stimulus(mk(4'b0001, 16'h0003, 0, 0, 4'b0001, 2'd0, 1, 4'd15), "quota_alone");
      apply_stimulus(mk(4'b0011, 16'h0003, 0, 0, 4'b0010, 2'd1, 1, 4'd1), "late_contender");
      apply_stimulus(mk(4'b0000, 16'h0003, 0, 0, 4'b0000, 2'd1, 0, 4'd0), "idle_again");

      // Asynchronous reset in the middle of a grant
      apply_stimulus(mk(4'b0100, 16'h0000, 0, 0, 4'b0100, 2'd2, 1, 4'd1), "pre_reset");
      #2 rst_n = 1'b0;
      #1 push_exp(4'b0000, 2'd3, 1'b0, 4'd0);
      check_output("async_reset", grant, grant_index, busy, hold_cnt);
      @(negedge clk);
      rst_n = 1'b1;
      apply_stimulus(mk(4'b1111, 16'h0000, 0, 0, 4'b0001, 2'd0, 1, 4'd1), "post_reset");
      req = '0;

      // Three requesters: wrap search and index range
      step3(3'b100, 3'b100, 2'd2, 1, 4'd1, "d3_wrap");
      step3(3'b000, 3'b000, 2'd2, 0, 4'd0, "d3_idle");
      step3(3'b100, 3'b100, 2'd2, 1, 4'd1, "d3_regrant");
      step3(3'b111, 3'b100, 2'd2, 1, 4'd2, "d3_hold");
      step3(3'b011, 3'b001, 2'd0, 1, 4'd1, "d3_rot0");
      step3(3'b110, 3'b010, 2'd1, 1, 4'd1, "d3_rot1");
      step3(3'b101, 3'b100, 2'd2, 1, 4'd1, "d3_rot2");
      step3(3'b011, 3'b001, 2'd0, 1, 4'd1, "d3_rot3");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
